uart_rx_line_fifo: RTL and testbench

//  Parametrised receive buffer between the uart core's RX side and downstream logic.

---
 rtl/uart_pkg.sv | 9 +
 rtl/uart_fifo_core.sv | 65 ++++++
 rtl/uart_rx_line_fifo.sv | 132 +++++++++++++
 tb/tb_uart_rx_line_fifo.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared character definitions for the uart receive path.
package uart_pkg;

   typedef logic [7:0] uart_char_t;

   localparam uart_char_t ASCII_CR = 8'h0D;
   localparam uart_char_t ASCII_LF = 8'h0A;

endpackage

// File: rtl/uart_fifo_core.sv
// Show-ahead FIFO storage with explicit pointer wrap, so DEPTH need not be a power of two.
// The caller qualifies i_wr/i_rd against full/empty and clear.
module uart_fifo_core #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned DEPTH      = 10,
   parameter int unsigned CNT_W      = $clog2(DEPTH + 1)
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  i_clr,
   input  logic                  i_wr,
   input  logic [DATA_WIDTH-1:0] i_wr_data,
   input  logic                  i_rd,
   output logic [DATA_WIDTH-1:0] o_rd_data,
   output logic [CNT_W-1:0]      o_count,
   output logic                  o_full,
   output logic                  o_empty
);

   localparam int unsigned      PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0]      r_wr_ptr;
   logic [PTR_W-1:0]      r_rd_ptr;
   logic [CNT_W-1:0]      r_count;

   // Storage is not reset; contents are only visible through rd_ptr once written.
   always_ff @(posedge clk) begin
      if (i_wr) begin
         r_mem[r_wr_ptr] <= i_wr_data;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (i_clr) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (i_wr) begin
            r_wr_ptr <= (r_wr_ptr == LAST_PTR) ? '0 : r_wr_ptr + PTR_W'(1);
         end
         if (i_rd) begin
            r_rd_ptr <= (r_rd_ptr == LAST_PTR) ? '0 : r_rd_ptr + PTR_W'(1);
         end
         case ({i_wr, i_rd})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   assign o_rd_data = r_mem[r_rd_ptr];
   assign o_count   = r_count;
   assign o_full    = (r_count == FULL_CNT);
   assign o_empty   = (r_count == '0);

endmodule

// File: rtl/uart_rx_line_fifo.sv
// UART receive buffer: FIFO with line-terminator counting and sticky overflow.
// Define UART_RX_LINE_FIFO_ECHO_EN to add a one-entry echo register towards uart TX.
module uart_rx_line_fifo
   import uart_pkg::*;
#(
   parameter int unsigned           DATA_WIDTH = 8,
   parameter int unsigned           DEPTH      = 10,
   parameter logic [DATA_WIDTH-1:0] TERM_CHAR  = DATA_WIDTH'(ASCII_CR),
   parameter int unsigned           CNT_W      = $clog2(DEPTH + 1)
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  ena,
   input  logic                  clear,
   input  logic [DATA_WIDTH-1:0] rx_data,
   input  logic                  rx_valid,
   output logic                  rx_ready,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  rd_valid,
   input  logic                  rd_ready,
   output logic [CNT_W-1:0]      count,
   output logic                  line_ready,
   output logic                  overflow,
   output logic [DATA_WIDTH-1:0] tx_data,
   output logic                  tx_valid,
   input  logic                  tx_ready
);

   logic                  w_full;
   logic                  w_empty;
   logic                  w_echo_free;
   logic                  w_rx_ready;
   logic                  w_rd_valid;
   logic                  w_wr;
   logic                  w_rd;
   logic                  w_clr;
   logic                  w_term_in;
   logic                  w_term_out;
   logic [DATA_WIDTH-1:0] w_rd_data;
   logic [CNT_W-1:0]      w_count;
   logic [CNT_W-1:0]      r_lines;
   logic                  r_overflow;

   assign w_clr      = ena & clear;
   assign w_rx_ready = ena & ~w_full & w_echo_free;
   assign w_rd_valid = ena & ~w_empty;
   // clear wins over a same-cycle write or read.
   assign w_wr       = rx_valid & w_rx_ready & ~clear;
   assign w_rd       = w_rd_valid & rd_ready & ~clear;
   assign w_term_in  = w_wr & (rx_data == TERM_CHAR);
   assign w_term_out = w_rd & (w_rd_data == TERM_CHAR);

   uart_fifo_core #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH),
      .CNT_W      (CNT_W)
   ) u_core (
      .clk       (clk),
      .reset_n   (reset_n),
      .i_clr     (w_clr),
      .i_wr      (w_wr),
      .i_wr_data (rx_data),
      .i_rd      (w_rd),
      .o_rd_data (w_rd_data),
      .o_count   (w_count),
      .o_full    (w_full),
      .o_empty   (w_empty)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_lines    <= '0;
         r_overflow <= 1'b0;
      end else if (ena) begin
         if (clear) begin
            r_lines    <= '0;
            r_overflow <= 1'b0;
         end else begin
            if (w_term_in && !w_term_out) begin
               r_lines <= r_lines + CNT_W'(1);
            end else if (!w_term_in && w_term_out) begin
               r_lines <= r_lines - CNT_W'(1);
            end
            if (rx_valid && !w_rx_ready) begin
               r_overflow <= 1'b1;
            end
         end
      end
   end

`ifdef UART_RX_LINE_FIFO_ECHO_EN
   logic                  r_echo_full;
   logic [DATA_WIDTH-1:0] r_echo_data;

   // A write is only accepted while the slot is empty, so load and drain never collide.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_echo_full <= 1'b0;
         r_echo_data <= '0;
      end else if (ena) begin
         if (clear) begin
            r_echo_full <= 1'b0;
            r_echo_data <= '0;
         end else if (w_wr) begin
            r_echo_full <= 1'b1;
            r_echo_data <= rx_data;
         end else if (r_echo_full && tx_ready) begin
            r_echo_full <= 1'b0;
         end
      end
   end

   assign w_echo_free = ~r_echo_full;
   assign tx_valid    = ena & r_echo_full;
   assign tx_data     = r_echo_data;
`else
   logic w_unused_tx_ready;

   assign w_unused_tx_ready = tx_ready;
   assign w_echo_free       = 1'b1;
   assign tx_valid          = 1'b0;
   assign tx_data           = '0;
`endif

   assign rx_ready   = w_rx_ready;
   assign rd_valid   = w_rd_valid;
   assign rd_data    = w_rd_data;
   assign count      = w_count;
   assign line_ready = (r_lines != '0);
   assign overflow   = r_overflow;

endmodule

// File: tb/tb_uart_rx_line_fifo.sv
// Randomised and directed checks of uart_rx_line_fifo against a queue-based reference model.
module tb_uart_rx_line_fifo;
   import uart_pkg::*;

   localparam int unsigned DEPTH = 10;
   localparam int unsigned CW    = $clog2(DEPTH + 1);
   localparam logic [7:0]  TERM  = 8'h0D;
`ifdef UART_RX_LINE_FIFO_ECHO_EN
   localparam bit ECHO = 1'b1;
`else
   localparam bit ECHO = 1'b0;
`endif

   logic          clk      = 1'b0;
   logic          reset_n  = 1'b0;
   logic          ena      = 1'b1;
   logic          clear    = 1'b0;
   logic [7:0]    rx_data  = 8'h00;
   logic          rx_valid = 1'b0;
   logic          rd_ready = 1'b0;
   logic          tx_ready = 1'b0;
   logic          rx_ready;
   logic [7:0]    rd_data;
   logic          rd_valid;
   logic [CW-1:0] count;
   logic          line_ready;
   logic          overflow;
   logic [7:0]    tx_data;
   logic          tx_valid;

   int         n_vec = 0;
   int         n_err = 0;
   logic [7:0] m_q[$];
   bit         m_ovf       = 1'b0;
   bit         m_echo_full = 1'b0;
   logic [7:0] m_echo_data = 8'h00;

   uart_rx_line_fifo #(
      .DATA_WIDTH (8),
      .DEPTH      (DEPTH),
      .TERM_CHAR  (TERM)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .ena        (ena),
      .clear      (clear),
      .rx_data    (rx_data),
      .rx_valid   (rx_valid),
      .rx_ready   (rx_ready),
      .rd_data    (rd_data),
      .rd_valid   (rd_valid),
      .rd_ready   (rd_ready),
      .count      (count),
      .line_ready (line_ready),
      .overflow   (overflow),
      .tx_data    (tx_data),
      .tx_valid   (tx_valid),
      .tx_ready   (tx_ready)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   function automatic int m_lines();
      int n = 0;
      foreach (m_q[i]) if (m_q[i] == TERM) n++;
      return n;
   endfunction

   // One clock: drive at negedge, compare against the model, then advance the model.
   task automatic cycle(input bit e, input bit c, input bit v, input logic [7:0] d,
                        input bit r, input bit t);
      bit exp_rxr;
      bit exp_rdv;
      bit wr;
      @(negedge clk);
      ena = e; clear = c; rx_valid = v; rx_data = d; rd_ready = r; tx_ready = t;
      #1;
      exp_rxr = e && (m_q.size() != DEPTH) && !m_echo_full;
      exp_rdv = e && (m_q.size() != 0);
      check_eq("rx_ready", rx_ready, exp_rxr);
      check_eq("rd_valid", rd_valid, exp_rdv);
      if (exp_rdv) check_eq("rd_data", rd_data, m_q[0]);
      check_eq("count", count, m_q.size());
      check_eq("line_ready", line_ready, m_lines() != 0);
      check_eq("overflow", overflow, m_ovf);
      check_eq("tx_valid", tx_valid, e && m_echo_full);
      if (e && m_echo_full) check_eq("tx_data", tx_data, m_echo_data);
      if (e) begin
         if (c) begin
            m_q.delete();
            m_ovf       = 1'b0;
            m_echo_full = 1'b0;
         end else begin
            wr = v && exp_rxr;
            if (v && !exp_rxr) m_ovf = 1'b1;
            if (exp_rdv && r) void'(m_q.pop_front());
            if (wr) m_q.push_back(d);
            if (wr && ECHO) begin
               m_echo_full = 1'b1;
               m_echo_data = d;
            end else if (m_echo_full && t) begin
               m_echo_full = 1'b0;
            end
         end
      end
      @(posedge clk);
   endtask

   // Drain a pending echo first so the write is never refused for that reason.
   task automatic put(input logic [7:0] ch, input bit r);
      if (m_echo_full) cycle(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
      cycle(1'b1, 1'b0, 1'b1, ch, r, 1'b1);
   endtask

   task automatic pop();
      cycle(1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
   endtask

   task automatic check_reset_vals(input string pfx);
      check_eq({pfx, "_count"}, count, 0);
      check_eq({pfx, "_rd_valid"}, rd_valid, 0);
      check_eq({pfx, "_line_ready"}, line_ready, 0);
      check_eq({pfx, "_overflow"}, overflow, 0);
      check_eq({pfx, "_tx_valid"}, tx_valid, 0);
      check_eq({pfx, "_rx_ready"}, rx_ready, 1);
   endtask

   task automatic mid_reset();
      @(negedge clk);
      ena = 1'b1; clear = 1'b0; rx_valid = 1'b0; rd_ready = 1'b0; tx_ready = 1'b0;
      #1 reset_n = 1'b0;
      #1 check_reset_vals("midrst");
      m_q.delete();
      m_ovf       = 1'b0;
      m_echo_full = 1'b0;
      #1 reset_n = 1'b1;
   endtask

   initial begin
      #3 check_reset_vals("rst");
      @(negedge clk);
      reset_n = 1'b1;

      // 1: three characters, head shows the first
      put(8'h41, 1'b0); put(8'h42, 1'b0); put(8'h43, 1'b0);
      #1;
      check_eq("t1_count", count, 3);
      check_eq("t1_head", rd_data, 8'h41);
      check_eq("t1_line_ready", line_ready, 0);

      // 2: fill, overflow on the eleventh, drain in order
      cycle(1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
      for (int i = 0; i < 10; i++) put(8'h61 + 8'(i), 1'b0);
      #1;
      check_eq("t2_full_count", count, 10);
      check_eq("t2_full_rx_ready", rx_ready, 0);
      put(8'h7A, 1'b0);
      #1;
      check_eq("t2_overflow", overflow, 1);
      check_eq("t2_count_after_drop", count, 10);
      for (int i = 0; i < 10; i++) begin
         #1 check_eq("t2_order", rd_data, 8'h61 + 8'(i));
         pop();
      end
      #1 check_eq("t2_empty_count", count, 0);

      // 3: full with simultaneous write and read
      for (int i = 0; i < 10; i++) put(8'h30 + 8'(i), 1'b0);
      put(8'h5A, 1'b1);
      #1;
      check_eq("t3_count", count, 9);
      check_eq("t3_overflow", overflow, 1);
      check_eq("t3_head", rd_data, 8'h31);

      // 4: line_ready tracks the stored CR
      cycle(1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
      #1 check_eq("t4_clear_overflow", overflow, 0);
      put(8'h48, 1'b0); put(8'h49, 1'b0);
      #1 check_eq("t4_line_before_cr", line_ready, 0);
      put(TERM, 1'b0);
      #1 check_eq("t4_line_after_cr", line_ready, 1);
      pop(); pop();
      #1 check_eq("t4_line_cr_at_head", line_ready, 1);
      pop();
      #1 check_eq("t4_line_after_pop", line_ready, 0);

      // 5: traffic across the pointer wrap, then clear
      cycle(1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
      for (int i = 0; i < 7; i++) put(8'h20 + 8'(i), 1'b0);
      for (int i = 0; i < 7; i++) pop();
      for (int i = 0; i < 6; i++) put(8'h50 + 8'(i), 1'b0);
      #1;
      check_eq("t5_count", count, 6);
      for (int i = 0; i < 3; i++) begin
         #1 check_eq("t5_order", rd_data, 8'h50 + 8'(i));
         pop();
      end
      cycle(1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
      #1;
      check_eq("t5_clr_count", count, 0);
      check_eq("t5_clr_rd_valid", rd_valid, 0);
      check_eq("t5_clr_overflow", overflow, 0);

`ifdef UART_RX_LINE_FIFO_ECHO_EN
      // 6: echo holds off further writes until TX takes it
      cycle(1'b1, 1'b0, 1'b1, 8'h78, 1'b0, 1'b0);
      #1;
      check_eq("t6_tx_valid", tx_valid, 1);
      check_eq("t6_tx_data", tx_data, 8'h78);
      check_eq("t6_rx_ready", rx_ready, 0);
      cycle(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
      #1 check_eq("t6_tx_hold", tx_valid, 1);
      cycle(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
      #1;
      check_eq("t6_tx_drained", tx_valid, 0);
      check_eq("t6_rx_ready_back", rx_ready, 1);
      cycle(1'b1, 1'b0, 1'b1, 8'h79, 1'b0, 1'b0);
`endif
      mid_reset();

      // Randomised traffic in fill / drain / mixed phases
      for (int n = 0; n < 3000; n++) begin
         bit         e;
         bit         c;
         bit         v;
         bit         r;
         bit         t;
         logic [7:0] d;
         int         phase;
         phase = (n / 150) % 3;
         e = ($urandom_range(0, 19) != 0);
         c = ($urandom_range(0, 99) == 0);
         if (phase == 0) begin
            v = ($urandom_range(0, 9) < 8);
            r = ($urandom_range(0, 9) < 2);
         end else if (phase == 1) begin
            v = ($urandom_range(0, 9) < 2);
            r = ($urandom_range(0, 9) < 8);
         end else begin
            v = $urandom_range(0, 1) != 0;
            r = $urandom_range(0, 1) != 0;
         end
         d = ($urandom_range(0, 3) == 0) ? TERM : 8'($urandom);
         t = $urandom_range(0, 1) != 0;
         cycle(e, c, v, d, r, t);
         if (n == 1500) mid_reset();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
